vdp_layer_pixel_shifter: RTL and testbench
==========================================

// Module: vdp_layer_pixel_shifter
//
// PURPOSE
// Parametrised per-layer tile pixel shifter for the VDP scroll layers.
// Accepts fetched tile rows plus palette/priority/flip metadata and double-buffers them.
// Reloads the shifter at the fine-scroll boundary and emits one registered
// {priority, palette, colour} pixel per clock for the layer compositor.
// Adds configurable bpp/tile width, h-flip, priority, layer enable and opacity flag.
//
// PARAMETERS
// BPP             4  bits per pixel (1,2,4,8); ROW_W = BPP*TILE_WIDTH
// TILE_WIDTH      8  pixels per tile row; power of 2, >=2; XW = $clog2(TILE_WIDTH)
// PALETTE_BITS    4  palette number width
// PRIORITY_BITS   2  priority field width (may be 0 -> port tied off, unused)
// STAGE_PIXEL_ROW 1  1: pixel_row captured on tile_row_load_enable; 0: taken direct at preload
//
// PORTS
// clk                          in   1             pixel clock
// reset_n                      in   1             async active-low reset
// scroll_x_granular            in   XW            layer fine scroll
// raster_x_granular            in   XW            low bits of raster x
// pixel_row                    in   ROW_W         fetched row, leftmost pixel in MSBs
// palette_number               in   PALETTE_BITS  tile palette
// tile_priority                in   PRIORITY_BITS tile priority
// tile_hflip                   in   1             mirror row horizontally
// layer_enable                 in   1             0 forces transparent output
// tile_row_load_enable         in   1             capture pixel_row (STAGE_PIXEL_ROW=1)
// meta_load_enable             in   1             capture palette/priority/hflip
// shifter_preload_load_enable  in   1             move staged tile into shifter preload
// pixel                        out  PALETTE_BITS+BPP  {palette, colour index}
// pixel_priority               out  PRIORITY_BITS registered priority of pixel
// pixel_opaque                 out  1             colour index != 0 and layer enabled
//
// BEHAVIOUR
// - reset_n low (async): all regs incl. pixel, pixel_priority, pixel_opaque = 0.
// - Stage 1: tile_row_load_enable -> row_pre <= pixel_row; meta_load_enable ->
//   {pal,pri,flip}_pre <= inputs. Independent; both may fire same cycle.
// - Stage 2: shifter_preload_load_enable -> row_t <= flip_pre ? pixel-reversed(src) : src,
//   src = STAGE_PIXEL_ROW ? row_pre : pixel_row; pal_t/pri_t <= pal_pre/pri_pre.
//   Reversal swaps whole BPP-wide pixel groups, never bits inside a pixel.
// - Same-edge load into stage 1 and stage 2: stage 2 takes OLD stage-1 contents.
// - Stage 3 (every cycle): reload when raster_x_granular == ~scroll_x_granular (XW bits,
//   i.e. TILE_WIDTH-1-scroll): row_out <= row_t, pal_out/pri_out <= pal_t/pri_t.
//   Else row_out <= row_out << BPP (zero fill); pal/pri held.
// - Reload same edge as stage-2 load: row_out takes OLD row_t.
// - Output: pixel <= {pal_out, row_out[ROW_W-1 -: BPP]}, pixel_priority <= pri_out,
//   pixel_opaque <= layer_enable && colour != 0; layer_enable=0 -> pixel=0, pri=0.
// - Latency: reload edge N -> first pixel of new tile on pixel after edge N+1.
// - After TILE_WIDTH shifts without reload colour is 0 (transparent), never stale data.
// - scroll change mid-line: reload point moves immediately; no other correction.
// - reset_n low mid-line: immediate clear; first pixel after release is 0 until reload.
// - Width rules: all compares are XW-bit unsigned with natural wrap.
//
// TESTING
// 1 Reset: drive reset_n=0 mid-stream -> pixel=0, pixel_opaque=0 same cycle, held.
// 2 Defaults, scroll=0, row=32'h1234_5678, pal=4'hA, preload then reload at raster=7 ->
//   pixel sequence 8'hA1,A2,...,A8 starting cycle after reload edge.
// 3 Same row, tile_hflip=1 -> 8'hA8,A7,...,A1; BPP=2 row=16'h1B1B -> 0,1,2,3 / 3,2,1,0.
// 4 scroll=3 -> reload at raster=4; 9 cycles w/o reload -> colour 0, pixel_opaque=0.
// 5 Simultaneous tile_row_load + preload (STAGE=1) -> shifter gets previous row; STAGE=0
//   -> new row directly.
// 6 layer_enable=0 with row=32'hFFFF_FFFF -> pixel=0, pixel_priority=0, opaque=0.

Source files
------------

// File: rtl/vdp_layer_pixel_shifter.sv
// Per-layer tile pixel shifter: stages fetched rows and tile metadata, then
// emits one registered {priority, palette, colour} pixel per clock.
module vdp_layer_pixel_shifter #(
    parameter int BPP             = 4,
    parameter int TILE_WIDTH      = 8,
    parameter int PALETTE_BITS    = 4,
    parameter int PRIORITY_BITS   = 2,
    parameter int STAGE_PIXEL_ROW = 1,
    localparam int ROW_W = BPP * TILE_WIDTH,
    localparam int XW    = $clog2(TILE_WIDTH),
    localparam int PW    = (PRIORITY_BITS > 0) ? PRIORITY_BITS : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [XW-1:0]               scroll_x_granular,
    input  logic [XW-1:0]               raster_x_granular,
    input  logic [ROW_W-1:0]            pixel_row,
    input  logic [PALETTE_BITS-1:0]     palette_number,
    input  logic [PW-1:0]               tile_priority,
    input  logic                        tile_hflip,
    input  logic                        layer_enable,
    input  logic                        tile_row_load_enable,
    input  logic                        meta_load_enable,
    input  logic                        shifter_preload_load_enable,
    output logic [PALETTE_BITS+BPP-1:0] pixel,
    output logic [PW-1:0]               pixel_priority,
    output logic                        pixel_opaque
);

    logic [ROW_W-1:0]        row_pre, row_t, row_out;
    logic [ROW_W-1:0]        row_src, row_rev;
    logic [PALETTE_BITS-1:0] pal_pre, pal_t, pal_out;
    logic [PW-1:0]           pri_pre, pri_t, pri_out, pri_in;
    logic                    flip_pre;
    logic [XW-1:0]           reload_x;
    logic                    reload;
    logic [BPP-1:0]          colour;

    // A zero-width priority field still occupies one bit, forced to 0.
    assign pri_in   = (PRIORITY_BITS > 0) ? tile_priority : '0;
    assign reload_x = ~scroll_x_granular;
    assign reload   = (raster_x_granular == reload_x);
    assign colour   = row_out[ROW_W-1 -: BPP];
    assign row_src  = (STAGE_PIXEL_ROW != 0) ? row_pre : pixel_row;

    // Mirror whole pixel groups; bit order inside a pixel is preserved.
    always_comb begin
        row_rev = '0;
        for (int i = 0; i < TILE_WIDTH; i++) begin
            row_rev[i*BPP +: BPP] = row_src[(TILE_WIDTH-1-i)*BPP +: BPP];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_pre  <= '0;
            pal_pre  <= '0;
            pri_pre  <= '0;
            flip_pre <= 1'b0;
        end else begin
            if (tile_row_load_enable) begin
                row_pre <= pixel_row;
            end
            if (meta_load_enable) begin
                pal_pre  <= palette_number;
                pri_pre  <= pri_in;
                flip_pre <= tile_hflip;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_t <= '0;
            pal_t <= '0;
            pri_t <= '0;
        end else if (shifter_preload_load_enable) begin
            row_t <= flip_pre ? row_rev : row_src;
            pal_t <= pal_pre;
            pri_t <= pri_pre;
        end
    end

    // Zero fill means an unreloaded shifter drains to transparent pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_out <= '0;
            pal_out <= '0;
            pri_out <= '0;
        end else if (reload) begin
            row_out <= row_t;
            pal_out <= pal_t;
            pri_out <= pri_t;
        end else begin
            row_out <= row_out << BPP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel          <= '0;
            pixel_priority <= '0;
            pixel_opaque   <= 1'b0;
        end else begin
            pixel          <= layer_enable ? {pal_out, colour} : '0;
            pixel_priority <= layer_enable ? pri_out : '0;
            pixel_opaque   <= layer_enable && (colour != '0);
        end
    end

endmodule

// File: tb/tb_vdp_layer_pixel_shifter.sv
// Directed bench for vdp_layer_pixel_shifter: default, 2bpp and
// direct-preload instances share control inputs.
module tb_vdp_layer_pixel_shifter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  scroll, raster;
    logic [31:0] row;
    logic [15:0] row_b;
    logic [3:0]  pal;
    logic [1:0]  pri;
    logic        flip, en, trl, mle, ple;
    logic [7:0]  pix_a, pix_c;
    logic [5:0]  pix_b;
    logic [1:0]  pri_a, pri_b, pri_c;
    logic        op_a, op_b, op_c;
    int          errors = 0;
    int          checks = 0;
    bit          hold = 1'b0;

    always #5 clk = ~clk;

    vdp_layer_pixel_shifter u_a (
        .clk(clk), .reset_n(reset_n),
        .scroll_x_granular(scroll), .raster_x_granular(raster),
        .pixel_row(row), .palette_number(pal), .tile_priority(pri),
        .tile_hflip(flip), .layer_enable(en),
        .tile_row_load_enable(trl), .meta_load_enable(mle),
        .shifter_preload_load_enable(ple),
        .pixel(pix_a), .pixel_priority(pri_a), .pixel_opaque(op_a)
    );

    vdp_layer_pixel_shifter #(.BPP(2)) u_b (
        .clk(clk), .reset_n(reset_n),
        .scroll_x_granular(scroll), .raster_x_granular(raster),
        .pixel_row(row_b), .palette_number(pal), .tile_priority(pri),
        .tile_hflip(flip), .layer_enable(en),
        .tile_row_load_enable(trl), .meta_load_enable(mle),
        .shifter_preload_load_enable(ple),
        .pixel(pix_b), .pixel_priority(pri_b), .pixel_opaque(op_b)
    );

    vdp_layer_pixel_shifter #(.STAGE_PIXEL_ROW(0)) u_c (
        .clk(clk), .reset_n(reset_n),
        .scroll_x_granular(scroll), .raster_x_granular(raster),
        .pixel_row(row), .palette_number(pal), .tile_priority(pri),
        .tile_hflip(flip), .layer_enable(en),
        .tile_row_load_enable(trl), .meta_load_enable(mle),
        .shifter_preload_load_enable(ple),
        .pixel(pix_c), .pixel_priority(pri_c), .pixel_opaque(op_c)
    );

    typedef struct {
        logic [31:0]      row;
        logic [15:0]      rowb;
        logic [3:0]       pal;
        logic [1:0]       pri;
        logic             flip;
        logic [2:0]       scroll;
        logic [0:7][7:0]  exp;
        logic [0:7][1:0]  expb;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold) raster = raster + 3'd1;
    endtask

    task automatic load_tile(input logic [31:0] r, input logic [15:0] rb,
                             input logic [3:0] p, input logic [1:0] q,
                             input logic f);
        row = r; row_b = rb; pal = p; pri = q; flip = f;
        trl = 1'b1; mle = 1'b1;
        tick();
        trl = 1'b0; mle = 1'b0; ple = 1'b1;
        tick();
        ple = 1'b0;
    endtask

    task automatic wait_reload(input string name);
        bit hit;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            hit = (raster == ~scroll);
            tick();
            if (hit) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: reload point never reached", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{32'h1234_5678, 16'h1B1B, 4'hA, 2'd1, 1'b0, 3'd0,
                  {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8},
                  {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3}};
        tv[1] = '{32'h1234_5678, 16'h1B1B, 4'hA, 2'd2, 1'b1, 3'd0,
                  {8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1},
                  {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tv[2] = '{32'h9ABC_DEF0, 16'hE400, 4'h3, 2'd3, 1'b0, 3'd3,
                  {8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h30},
                  {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        tv[3] = '{32'h0F00_00F1, 16'hE400, 4'h5, 2'd0, 1'b1, 3'd5,
                  {8'h51, 8'h5F, 8'h50, 8'h50, 8'h50, 8'h50, 8'h5F, 8'h50},
                  {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3}};

        reset_n = 1'b0; scroll = 3'd0; raster = 3'd0; row = '0; row_b = '0;
        pal = '0; pri = '0; flip = 1'b0; en = 1'b1;
        trl = 1'b0; mle = 1'b0; ple = 1'b0;
        #12;
        chk("reset_pixel", {24'd0, pix_a}, 32'd0);
        chk("reset_opaque", {31'd0, op_a}, 32'd0);
        chk("reset_prio", {30'd0, pri_a}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            scroll = tv[v].scroll;
            load_tile(tv[v].row, tv[v].rowb, tv[v].pal, tv[v].pri, tv[v].flip);
            wait_reload("vec_reload");
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("vec_pixel_a", {24'd0, pix_a}, {24'd0, tv[v].exp[k]});
                chk("vec_prio_a", {30'd0, pri_a}, {30'd0, tv[v].pri});
                chk("vec_opaque_a", {31'd0, op_a},
                    {31'd0, tv[v].exp[k][3:0] != 4'd0});
                chk("vec_pixel_c", {24'd0, pix_c}, {24'd0, tv[v].exp[k]});
                chk("vec_pixel_b", {26'd0, pix_b},
                    {26'd0, tv[v].pal, tv[v].expb[k]});
            end
        end

        scroll = 3'd3;
        load_tile(32'hFFFF_FFFF, 16'hFFFF, 4'h1, 2'd2, 1'b0);
        wait_reload("drain_reload");
        hold = 1'b1;
        repeat (8) tick();
        chk("drain_last_pixel", {24'd0, pix_a}, 32'h1F);
        chk("drain_last_opaque", {31'd0, op_a}, 32'd1);
        tick();
        chk("drain_empty_pixel", {24'd0, pix_a}, 32'h10);
        chk("drain_empty_opaque", {31'd0, op_a}, 32'd0);
        hold = 1'b0;

        scroll = 3'd0;
        row = 32'h7000_0000; row_b = '0; pal = 4'h6; pri = 2'd1; flip = 1'b0;
        trl = 1'b1; mle = 1'b1;
        tick();
        row = 32'h2000_0000; mle = 1'b0; ple = 1'b1;
        tick();
        trl = 1'b0; ple = 1'b0;
        wait_reload("same_edge_reload");
        tick();
        chk("stage1_old_row", {24'd0, pix_a}, 32'h67);
        chk("direct_new_row", {24'd0, pix_c}, 32'h62);

        row = 32'h3000_0000; trl = 1'b1;
        tick();
        trl = 1'b0;
        for (int i = 0; i < 16 && raster != ~scroll; i++) tick();
        ple = 1'b1;
        tick();
        ple = 1'b0;
        tick();
        chk("reload_old_row_t_a", {24'd0, pix_a}, 32'h67);
        chk("reload_old_row_t_c", {24'd0, pix_c}, 32'h62);

        en = 1'b0;
        load_tile(32'hFFFF_FFFF, 16'hFFFF, 4'hF, 2'd3, 1'b0);
        wait_reload("disable_reload");
        repeat (2) begin
            tick();
            chk("disabled_pixel", {24'd0, pix_a}, 32'd0);
            chk("disabled_prio", {30'd0, pri_a}, 32'd0);
            chk("disabled_opaque", {31'd0, op_a}, 32'd0);
        end

        en = 1'b1;
        wait_reload("pre_reset_reload");
        tick();
        chk("pre_reset_pixel", {24'd0, pix_a}, 32'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pixel", {24'd0, pix_a}, 32'd0);
        chk("async_reset_opaque", {31'd0, op_a}, 32'd0);
        tick();
        tick();
        chk("reset_held_pixel", {24'd0, pix_a}, 32'd0);
        reset_n = 1'b1;
        repeat (2) begin
            tick();
            chk("post_reset_pixel", {24'd0, pix_a}, 32'd0);
            chk("post_reset_opaque", {31'd0, op_a}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
